bcd_entry_to_bin: RTL and testbench

Sequential decimal-to-binary converter: the inverse of the switch-to-seven-segment display path. It accepts four BCD digits, a sign flag and the unsigned/signed mode, and produces the 10-bit binary value that the display path would show as that decimal number. The value is built iteratively (acc = acc*10 + digit, one digit per cycle), with range and digit validity checks. It sits between a digit-entry front end (switches/keys) and any block consuming a 10-bit SW-equivalent word.

---
 rtl/bcd_entry_to_bin.sv | 154 +++++++++++++++
 tb/tb_bcd_entry_to_bin.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_entry_to_bin.sv
// Iterative four-digit BCD to 10-bit binary converter.
// Signed or unsigned result with range and digit checks.
module bcd_entry_to_bin #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 10
) (
  input  logic                  CLOCK_50,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode_unsigned,
  input  logic                  negative,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      value,
  output logic                  error
);

  localparam int AW = $clog2(10 ** DIGITS);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [AW-1:0] LIM_U   = AW'(2 ** WIDTH - 1);
  localparam logic [AW-1:0] LIM_POS = AW'(2 ** (WIDTH - 1) - 1);
  localparam logic [AW-1:0] LIM_NEG = AW'(2 ** (WIDTH - 1));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t                r_state;
  logic [4*DIGITS-1:0]   r_bcd;
  logic                  r_neg;
  logic                  r_mu;
  logic [AW-1:0]         r_acc;
  logic [IW-1:0]         r_idx;
  logic                  r_bad;
  logic                  r_done;
  logic [WIDTH-1:0]      r_value;
  logic                  r_error;

  state_t                w_state_nx;
  logic [4*DIGITS-1:0]   w_bcd_nx;
  logic                  w_neg_nx;
  logic                  w_mu_nx;
  logic [AW-1:0]         w_acc_nx;
  logic [IW-1:0]         w_idx_nx;
  logic                  w_bad_nx;
  logic                  w_done_nx;
  logic [WIDTH-1:0]      w_value_nx;
  logic                  w_error_nx;

  logic [3:0]            w_digit;
  logic [AW-1:0]         w_limit;
  logic [WIDTH-1:0]      w_twos;

  assign w_digit = r_bcd[{r_idx, 2'b00} +: 4];
  assign w_twos  = WIDTH'(0) - r_acc[WIDTH-1:0];

  always_comb begin
    w_limit = LIM_U;
    if (!r_mu) begin
      w_limit = r_neg ? LIM_NEG : LIM_POS;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_bcd_nx   = r_bcd;
    w_neg_nx   = r_neg;
    w_mu_nx    = r_mu;
    w_acc_nx   = r_acc;
    w_idx_nx   = r_idx;
    w_bad_nx   = r_bad;
    w_done_nx  = 1'b0;
    w_value_nx = r_value;
    w_error_nx = r_error;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_bcd_nx   = bcd_in;
          w_neg_nx   = negative;
          w_mu_nx    = mode_unsigned;
          w_acc_nx   = '0;
          w_idx_nx   = IW'(DIGITS - 1);
          w_bad_nx   = 1'b0;
          w_state_nx = ACCUM;
        end
      end
      ACCUM: begin
        w_acc_nx = r_acc * AW'(10) + AW'(w_digit);
        if (w_digit > 4'd9) begin
          w_bad_nx = 1'b1;
        end
        if (r_idx == '0) begin
          w_state_nx = CHECK;
        end else begin
          w_idx_nx = r_idx - 1'b1;
        end
      end
      CHECK: begin
        // negative zero falls out of the two's complement as plain zero
        if (r_bad || (r_acc > w_limit)) begin
          w_error_nx = 1'b1;
          w_value_nx = '0;
        end else if (!r_mu && r_neg) begin
          w_error_nx = 1'b0;
          w_value_nx = w_twos;
        end else begin
          w_error_nx = 1'b0;
          w_value_nx = r_acc[WIDTH-1:0];
        end
        w_done_nx  = 1'b1;
        w_state_nx = IDLE;
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      r_state <= IDLE;
      r_bcd   <= '0;
      r_neg   <= 1'b0;
      r_mu    <= 1'b0;
      r_acc   <= '0;
      r_idx   <= '0;
      r_bad   <= 1'b0;
      r_done  <= 1'b0;
      r_value <= '0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_bcd   <= w_bcd_nx;
      r_neg   <= w_neg_nx;
      r_mu    <= w_mu_nx;
      r_acc   <= w_acc_nx;
      r_idx   <= w_idx_nx;
      r_bad   <= w_bad_nx;
      r_done  <= w_done_nx;
      r_value <= w_value_nx;
      r_error <= w_error_nx;
    end
  end

  assign busy  = (r_state != IDLE);
  assign done  = r_done;
  assign value = r_value;
  assign error = r_error;

endmodule

// File: tb/tb_bcd_entry_to_bin.sv
// Randomized and directed bench for bcd_entry_to_bin.
// Reference model works on decimal arithmetic.
module tb_bcd_entry_to_bin;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mode_unsigned;
  logic        negative;
  logic [15:0] bcd_in;
  logic        busy;
  logic        done;
  logic [9:0]  value;
  logic        error;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bcd_entry_to_bin #(
    .DIGITS(4),
    .WIDTH (10)
  ) dut (
    .CLOCK_50     (clk),
    .rst          (rst),
    .start        (start),
    .mode_unsigned(mode_unsigned),
    .negative     (negative),
    .bcd_in       (bcd_in),
    .busy         (busy),
    .done         (done),
    .value        (value),
    .error        (error)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // returns {error, value}
  function automatic logic [10:0] model(input logic [15:0] b,
                                        input logic n,
                                        input logic u);
    int v;
    int lim;
    int d;
    bit bad;
    v   = 0;
    bad = 0;
    for (int i = 3; i >= 0; i--) begin
      d = int'(b[i*4 +: 4]);
      if (d > 9) bad = 1;
      v = v * 10 + d;
    end
    lim = u ? 1023 : (n ? 512 : 511);
    if (bad || v > lim) return {1'b1, 10'd0};
    if (!u && n) return {1'b0, 10'((1024 - v) % 1024)};
    return {1'b0, 10'(v)};
  endfunction

  task automatic quiet(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk(tag, 32'(done), 32'd0);
    end
  endtask

  // poke: re-pulse start two cycles in and confirm it is not queued
  task automatic conv(input logic [15:0] b, input logic n,
                      input logic u, input bit poke);
    logic [10:0] exp;
    int cyc;
    exp = model(b, n, u);
    @(negedge clk);
    bcd_in        = b;
    negative      = n;
    mode_unsigned = u;
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    while (!done && cyc < 20) begin
      chk("busy", 32'(busy), 32'd1);
      bcd_in        = 16'($urandom);
      negative      = 1'($urandom);
      mode_unsigned = 1'($urandom);
      start         = (poke && cyc == 1);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("latency", 32'(cyc), 32'd5);
    chk("busy_done", 32'(busy), 32'd0);
    chk("value", 32'(value), 32'(exp[9:0]));
    chk("error", 32'(error), 32'(exp[10]));
    if (poke) quiet("no_requeue", 7);
  endtask

  initial begin
    logic [15:0] b;
    int d;
    int first;
    int second;
    int cnt;
    rst           = 1'b1;
    start         = 1'b0;
    mode_unsigned = 1'b1;
    negative      = 1'b0;
    bcd_in        = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_value", 32'(value), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    rst = 1'b0;

    conv(16'h0015, 1'b0, 1'b1, 1'b0);
    conv(16'h1023, 1'b0, 1'b1, 1'b0);
    conv(16'h1024, 1'b0, 1'b1, 1'b0);
    conv(16'h0000, 1'b0, 1'b1, 1'b0);
    conv(16'h0512, 1'b1, 1'b0, 1'b0);
    conv(16'h0001, 1'b1, 1'b0, 1'b0);
    conv(16'h0511, 1'b0, 1'b0, 1'b0);
    conv(16'h0512, 1'b0, 1'b0, 1'b0);
    conv(16'h0513, 1'b1, 1'b0, 1'b0);
    conv(16'h0000, 1'b1, 1'b0, 1'b0);
    conv(16'h00A2, 1'b0, 1'b1, 1'b0);
    conv(16'h0345, 1'b0, 1'b1, 1'b0);
    conv(16'h0777, 1'b0, 1'b1, 1'b1);

    // start held for ten edges: two results six cycles apart
    @(negedge clk);
    bcd_in        = 16'h0042;
    mode_unsigned = 1'b1;
    start         = 1'b1;
    first  = -1;
    second = -1;
    cnt    = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 9) start = 1'b0;
      if (done) begin
        cnt++;
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
    end
    start = 1'b0;
    chk("held_count", 32'(cnt), 32'd2);
    chk("held_gap", 32'(second - first), 32'd6);
    chk("held_value", 32'(value), 32'h02A);

    // reset at the third accumulate edge aborts quietly
    conv(16'h0123, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    bcd_in = 16'h0456;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_value", 32'(value), 32'd0);
    chk("abort_error", 32'(error), 32'd0);
    quiet("abort_nodone", 8);
    conv(16'h0456, 1'b1, 1'b0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      b = '0;
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 9) == 0) d = int'($urandom_range(10, 15));
        else if (i == 3) d = int'($urandom_range(0, 1));
        else d = int'($urandom_range(0, 9));
        b[i*4 +: 4] = 4'(d);
      end
      conv(b, 1'($urandom), 1'($urandom), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
